// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl
// Sequencer for a WIDTH-bit shift register run as a ring counter (one-hot
// rotate) or a Johnson counter (twisted rotate). A start/stop handshake
// launches a run that loads the mode's seed and then shifts either for a
// programmed number of steps or until stopped. busy/done/wrap are reported
// as registered status for the surrounding top level.
//
// Build option: define SHIFT_SEQ_DIR_EN to add the `dir` port and the
// shift-toward-LSB variants. Without it the register only shifts toward
// the MSB, which matches dir = 0.

module shift_seq_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             stop,
   input  logic             mode_req,
   input  logic [7:0]       len,
`ifdef SHIFT_SEQ_DIR_EN
   input  logic             dir,
`endif
   output logic [WIDTH-1:0] out,
   output logic             busy,
   output logic             done,
   output logic             wrap
);

   // State encoding kept as plain constants so older tools and scripts can
   // decode the state register directly.
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_LOAD = 2'd1;
   localparam logic [1:0] ST_RUN  = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   // Seed for the selected mode: ring starts one-hot at bit 0, Johnson
   // starts from all zeros.
   function automatic logic [WIDTH-1:0] seed_of(input logic johnson);
      logic [WIDTH-1:0] seed;
      seed = {WIDTH{1'b0}};
      if (johnson == 1'b0) begin
         seed[0] = 1'b1;
      end else begin
         seed[0] = 1'b0;
      end
      return seed;
   endfunction

   // One step of the counter. The bit rotated in from the far end is
   // inverted for Johnson mode, passed straight through for ring mode.
   function automatic logic [WIDTH-1:0] shift_next(
      input logic [WIDTH-1:0] cur,
      input logic             johnson,
      input logic             right
   );
      logic             feed;
      logic [WIDTH-1:0] nxt;
      if (right == 1'b1) begin
         feed = cur[0] ^ johnson;
         nxt  = {feed, cur[WIDTH-1:1]};
      end else begin
         feed = cur[WIDTH-1] ^ johnson;
         nxt  = {cur[WIDTH-2:0], feed};
      end
      return nxt;
   endfunction

   // Registered state
   logic [1:0]       state_r;
   logic [WIDTH-1:0] out_r;
   logic [7:0]       step_r;
   logic             mode_r;
   logic [7:0]       len_r;
   logic             busy_r;
   logic             done_r;
   logic             wrap_r;

   // Next-state values
   logic [1:0]       state_s;
   logic [WIDTH-1:0] out_s;
   logic [7:0]       step_s;
   logic             mode_s;
   logic [7:0]       len_s;
   logic             busy_s;
   logic             done_s;
   logic             wrap_s;

   // Helpers derived from the captured run configuration
   logic             dir_sel_s;
   logic [WIDTH-1:0] seed_s;
   logic [WIDTH-1:0] shifted_s;
   logic [7:0]       step_inc_s;
   logic             len_hit_s;
   logic             accept_s;

`ifdef SHIFT_SEQ_DIR_EN
   logic dir_r;
   logic dir_s;

   // Direction is captured with the other run parameters when start is taken.
   always_comb begin
      if (accept_s == 1'b1) begin
         dir_s = dir;
      end else begin
         dir_s = dir_r;
      end
   end

   // Captured direction register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dir_r <= 1'b0;
      end else begin
         dir_r <= dir_s;
      end
   end

   assign dir_sel_s = dir_r;
`else
   assign dir_sel_s = 1'b0;
`endif

   assign accept_s   = (state_r == ST_IDLE) && (start == 1'b1);
   assign seed_s     = seed_of(mode_r);
   assign shifted_s  = shift_next(out_r, mode_r, dir_sel_s);
   assign step_inc_s = step_r + 8'd1;
   // A zero length means free-run, so the counter reaching zero after a
   // wrap never ends the run.
   assign len_hit_s  = (len_r != 8'd0) && (step_inc_s == len_r);

   // Sequencer next-state logic: capture, seed load, shift/count, finish.
   always_comb begin
      state_s = state_r;
      out_s   = out_r;
      step_s  = step_r;
      mode_s  = mode_r;
      len_s   = len_r;
      wrap_s  = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (accept_s == 1'b1) begin
               state_s = ST_LOAD;
               mode_s  = mode_req;
               len_s   = len;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_LOAD: begin
            out_s   = seed_s;
            step_s  = 8'd0;
            state_s = ST_RUN;
         end
         ST_RUN: begin
            // stop wins over both the shift and a length completion
            if (stop == 1'b1) begin
               state_s = ST_DONE;
            end else begin
               out_s  = shifted_s;
               step_s = step_inc_s;
               wrap_s = (shifted_s == seed_s);
               if (len_hit_s == 1'b1) begin
                  state_s = ST_DONE;
               end else begin
                  state_s = ST_RUN;
               end
            end
         end
         ST_DONE: begin
            state_s = ST_IDLE;
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // Status outputs are decoded from the next state so they line up with
   // the state they describe while still coming straight from flops.
   always_comb begin
      busy_s = (state_s == ST_LOAD) || (state_s == ST_RUN);
      done_s = (state_s == ST_DONE);
   end

   // Sequencer and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
         out_r   <= {WIDTH{1'b0}};
         step_r  <= 8'd0;
         mode_r  <= 1'b0;
         len_r   <= 8'd0;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
         wrap_r  <= 1'b0;
      end else begin
         state_r <= state_s;
         out_r   <= out_s;
         step_r  <= step_s;
         mode_r  <= mode_s;
         len_r   <= len_s;
         busy_r  <= busy_s;
         done_r  <= done_s;
         wrap_r  <= wrap_s;
      end
   end

   assign out  = out_r;
   assign busy = busy_r;
   assign done = done_r;
   assign wrap = wrap_r;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed self-checking bench for shift_seq_ctrl (WIDTH = 8). Expected
// per-cycle outputs are queued as stimulus is applied and compared when
// the DUT output is sampled on the falling edge.

module tb_shift_seq_ctrl;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic       stop;
   logic       mode_req;
   logic [7:0] len;
`ifdef SHIFT_SEQ_DIR_EN
   logic       dir;
`endif
   logic [7:0] out;
   logic       busy;
   logic       done;
   logic       wrap;

   typedef struct {
      string      tag;
      logic [7:0] out;
      logic       busy;
      logic       done;
      logic       wrap;
   } exp_t;

   exp_t sb_q[$];
   int   pass_cnt  = 0;
   int   total_cnt = 0;

   shift_seq_ctrl #(.WIDTH(8)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .stop     (stop),
      .mode_req (mode_req),
      .len      (len),
`ifdef SHIFT_SEQ_DIR_EN
      .dir      (dir),
`endif
      .out      (out),
      .busy     (busy),
      .done     (done),
      .wrap     (wrap)
   );

   // 10-unit clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Run-time bound
   initial begin
      #100000;
      $display("FAIL watchdog: observed no finish expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic push(input string tag, input logic [7:0] o, input logic b,
                       input logic d, input logic w);
      exp_t e;
      e.tag  = tag;
      e.out  = o;
      e.busy = b;
      e.done = d;
      e.wrap = w;
      sb_q.push_back(e);
   endtask

   task automatic check_now();
      exp_t e;
      cmp("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
         e = sb_q.pop_front();
         cmp({e.tag, "_out"},  32'(out),  32'(e.out));
         cmp({e.tag, "_busy"}, 32'(busy), 32'(e.busy));
         cmp({e.tag, "_done"}, 32'(done), 32'(e.done));
         cmp({e.tag, "_wrap"}, 32'(wrap), 32'(e.wrap));
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
      check_now();
   endtask

   initial begin
      logic [7:0] j_tab [16];
      logic [7:0] v;
      j_tab = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF,
                8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80, 8'h00};

      rst_n    = 1'b0;
      start    = 1'b0;
      stop     = 1'b0;
      mode_req = 1'b0;
      len      = 8'd0;
`ifdef SHIFT_SEQ_DIR_EN
      dir      = 1'b0;
`endif
      #1;
      push("reset", 8'h00, 1'b0, 1'b0, 1'b0);
      check_now();
      @(negedge clk);
      rst_n = 1'b1;
      push("idle0", 8'h00, 1'b0, 1'b0, 1'b0);
      cyc();

      // Ring, len = 3
      start = 1'b1; mode_req = 1'b0; len = 8'd3;
      push("r3_load", 8'h00, 1'b1, 1'b0, 1'b0); cyc();
      start = 1'b0;
      push("r3_seed", 8'h01, 1'b1, 1'b0, 1'b0); cyc();
      push("r3_s1",   8'h02, 1'b1, 1'b0, 1'b0); cyc();
      push("r3_s2",   8'h04, 1'b1, 1'b0, 1'b0); cyc();
      push("r3_s3",   8'h08, 1'b0, 1'b1, 1'b0); cyc();
      push("r3_idle", 8'h08, 1'b0, 1'b0, 1'b0); cyc();

      // Johnson, len = 16: final shift returns to the seed
      start = 1'b1; mode_req = 1'b1; len = 8'd16;
      push("j16_load", 8'h08, 1'b1, 1'b0, 1'b0); cyc();
      start = 1'b0;
      push("j16_seed", 8'h00, 1'b1, 1'b0, 1'b0); cyc();
      for (int k = 0; k < 16; k++) begin
         if (k == 15) push("j16_last", j_tab[k], 1'b0, 1'b1, 1'b1);
         else         push("j16_step", j_tab[k], 1'b1, 1'b0, 1'b0);
         cyc();
      end
      push("j16_idle", 8'h00, 1'b0, 1'b0, 1'b0); cyc();

      // Ring free-run past 256 steps, then stop while out = 10
      start = 1'b1; mode_req = 1'b0; len = 8'd0;
      push("fr_load", 8'h00, 1'b1, 1'b0, 1'b0); cyc();
      start = 1'b0;
      push("fr_seed", 8'h01, 1'b1, 1'b0, 1'b0); cyc();
      for (int k = 1; k <= 260; k++) begin
         v = 8'h01 << (k % 8);
         push("fr_step", v, 1'b1, 1'b0, ((k % 8) == 0));
         cyc();
      end
      stop = 1'b1;
      push("fr_stop", 8'h10, 1'b0, 1'b1, 1'b0); cyc();
      push("fr_idle_stop", 8'h10, 1'b0, 1'b0, 1'b0); cyc();
      stop = 1'b0;
      push("fr_idle", 8'h10, 1'b0, 1'b0, 1'b0); cyc();

      // Mid-run changes to mode/len and a start pulse are ignored
      start = 1'b1; mode_req = 1'b0; len = 8'd4;
      push("mr_load", 8'h10, 1'b1, 1'b0, 1'b0); cyc();
      start = 1'b0; mode_req = 1'b1; len = 8'd1;
      push("mr_seed", 8'h01, 1'b1, 1'b0, 1'b0); cyc();
      start = 1'b1;
      push("mr_s1", 8'h02, 1'b1, 1'b0, 1'b0); cyc();
      start = 1'b0;
      push("mr_s2", 8'h04, 1'b1, 1'b0, 1'b0); cyc();
      push("mr_s3", 8'h08, 1'b1, 1'b0, 1'b0); cyc();
      push("mr_s4", 8'h10, 1'b0, 1'b1, 1'b0); cyc();
      start = 1'b1;
      push("mr_done_start", 8'h10, 1'b0, 1'b0, 1'b0); cyc();
      start = 1'b0;
      push("mr_idle1", 8'h10, 1'b0, 1'b0, 1'b0); cyc();
      push("mr_idle2", 8'h10, 1'b0, 1'b0, 1'b0); cyc();

      // Asynchronous reset in the middle of a run
      start = 1'b1; mode_req = 1'b0; len = 8'd0;
      push("ar_load", 8'h10, 1'b1, 1'b0, 1'b0); cyc();
      start = 1'b0;
      push("ar_seed", 8'h01, 1'b1, 1'b0, 1'b0); cyc();
      push("ar_s1",   8'h02, 1'b1, 1'b0, 1'b0); cyc();
      #2;
      rst_n = 1'b0;
      #1;
      push("ar_async", 8'h00, 1'b0, 1'b0, 1'b0); check_now();
      @(posedge clk);
      #1;
      push("ar_held", 8'h00, 1'b0, 1'b0, 1'b0); check_now();
      @(negedge clk);
      rst_n = 1'b1;
      push("ar_idle1", 8'h00, 1'b0, 1'b0, 1'b0); cyc();
      push("ar_idle2", 8'h00, 1'b0, 1'b0, 1'b0); cyc();

`ifdef SHIFT_SEQ_DIR_EN
      // Right-shifting ring and Johnson, len = 2
      start = 1'b1; mode_req = 1'b0; len = 8'd2; dir = 1'b1;
      push("rr_load", 8'h00, 1'b1, 1'b0, 1'b0); cyc();
      start = 1'b0; dir = 1'b0;
      push("rr_seed", 8'h01, 1'b1, 1'b0, 1'b0); cyc();
      push("rr_s1",   8'h80, 1'b1, 1'b0, 1'b0); cyc();
      push("rr_s2",   8'h40, 1'b0, 1'b1, 1'b0); cyc();
      push("rr_idle", 8'h40, 1'b0, 1'b0, 1'b0); cyc();
      start = 1'b1; mode_req = 1'b1; len = 8'd2; dir = 1'b1;
      push("jr_load", 8'h40, 1'b1, 1'b0, 1'b0); cyc();
      start = 1'b0;
      push("jr_seed", 8'h00, 1'b1, 1'b0, 1'b0); cyc();
      push("jr_s1",   8'h80, 1'b1, 1'b0, 1'b0); cyc();
      push("jr_s2",   8'hC0, 1'b0, 1'b1, 1'b0); cyc();
      push("jr_idle", 8'hC0, 1'b0, 1'b0, 1'b0); cyc();
`endif

      cmp("sb_drained", 32'(sb_q.size()), 32'd0);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
